// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation datapath and its precompute stage.
package rsa_pkg;

    localparam int unsigned RSA_WIDTH = 8;
    localparam int unsigned CNT_W     = $clog2(2 * RSA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [RSA_WIDTH-1:0] operand_t;

endpackage

// File: rtl/rsa_mod_dbl_step.sv
// Combinational modular doubling: (2*a) mod m for a < m, m < 2^WIDTH.
module rsa_mod_dbl_step
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   result_c
);

    localparam int unsigned AW = WIDTH + 1;

    logic [WIDTH:0] dbl;
    logic [WIDTH:0] m_ext;

    // a < m keeps the top bit of a clear, so the doubled value fits in WIDTH+1 bits
    // and a single conditional subtract fully reduces it.
    always_comb begin
        dbl      = {a[WIDTH-1:0], 1'b0};
        m_ext    = AW'(m);
        result_c = dbl;
        if (dbl >= m_ext) begin
            result_c = dbl - m_ext;
        end
    end

endmodule

// File: rtl/rsa_mont_precompute.sv
// Bit-serial computation of the Montgomery constants R^2 mod M and -M^-1 mod 2^WIDTH.
module rsa_mont_precompute
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] r2_mod,
    output logic [WIDTH-1:0] m_prime
);

    localparam int unsigned AW = WIDTH + 1;
    localparam int unsigned CW = $clog2(2 * WIDTH);
    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] m_lat;
    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] acc_t;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   acc_r_next_c;
    logic [IW-1:0]    bit_idx_c;
    logic             inv_active_c;

    rsa_mod_dbl_step #(.WIDTH(WIDTH)) u_dbl (
        .a        (acc_r),
        .m        (m_lat),
        .result_c (acc_r_next_c)
    );

    // Inverse loop only touches one bit per cycle during the first WIDTH steps.
    always_comb begin
        inv_active_c = (32'(cnt) < WIDTH);
        bit_idx_c    = cnt[IW-1:0];
    end

    // Control FSM, counter, accumulators and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            r2_mod  <= '0;
            m_prime <= '0;
            m_lat   <= '0;
            acc_r   <= '0;
            acc_t   <= '0;
            q       <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (modulus[0]) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            m_lat <= modulus;
                            // With M=1 the residue of 1 is already 0; seeding 0 keeps acc_r < M.
                            acc_r <= (modulus == WIDTH'(1)) ? '0 : AW'(1);
                            acc_t <= '0;
                            q     <= '0;
                            cnt   <= '0;
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            r2_mod  <= '0;
                            m_prime <= '0;
                        end
                    end
                end
                RUN: begin
                    acc_r <= acc_r_next_c;
                    // Force bit cnt of M*q to one; after WIDTH steps M*q = -1 mod 2^WIDTH.
                    if (inv_active_c && !acc_t[bit_idx_c]) begin
                        q[bit_idx_c] <= 1'b1;
                        acc_t        <= acc_t + (m_lat << bit_idx_c);
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        r2_mod  <= acc_r_next_c[WIDTH-1:0];
                        m_prime <= q;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_mont_precompute.sv
// Directed bench for the Montgomery constant precompute stage.
module tb_rsa_mont_precompute;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] modulus;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] r2_mod;
    logic [7:0] m_prime;

    int n_vec;
    int n_bad;

    rsa_mont_precompute #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .modulus (modulus),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .r2_mod  (r2_mod),
        .m_prime (m_prime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; return cycle index of done (cycle 0 = accept) and busy count.
    task automatic do_run(input logic [7:0] m, output int lat, output int busy_cnt);
        @(posedge clk); #1;
        start   = 1'b1;
        modulus = m;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int lat;
    int bcnt;
    int dcnt;
    logic [31:0] prod;

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        modulus = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_done",    32'(done),    32'h0);
        chk("rst_err",     32'(err),     32'h0);
        chk("rst_r2",      32'(r2_mod),  32'h0);
        chk("rst_mprime",  32'(m_prime), 32'h0);
        rst = 1'b0;

        // Main vector M=0xB3
        do_run(8'hB3, lat, bcnt);
        chk("b3_lat",    32'(lat),     32'd17);
        chk("b3_busy",   32'(bcnt),    32'd16);
        chk("b3_r2",     32'(r2_mod),  32'h16);
        chk("b3_mprime", 32'(m_prime), 32'h85);
        chk("b3_err",    32'(err),     32'h0);
        @(posedge clk); #1;
        chk("b3_done_pulse", 32'(done), 32'h0);

        do_run(8'hFF, lat, bcnt);
        chk("ff_r2",     32'(r2_mod),  32'h01);
        chk("ff_mprime", 32'(m_prime), 32'h01);
        do_run(8'h03, lat, bcnt);
        chk("03_r2",     32'(r2_mod),  32'h01);
        chk("03_mprime", 32'(m_prime), 32'h55);
        do_run(8'h01, lat, bcnt);
        chk("01_r2",     32'(r2_mod),  32'h00);
        chk("01_mprime", 32'(m_prime), 32'hFF);

        // Even modulus error path
        do_run(8'h10, lat, bcnt);
        chk("even_lat",    32'(lat),     32'd1);
        chk("even_err",    32'(err),     32'h1);
        chk("even_r2",     32'(r2_mod),  32'h0);
        chk("even_mprime", 32'(m_prime), 32'h0);
        do_run(8'hB3, lat, bcnt);
        chk("recover_err",    32'(err),     32'h0);
        chk("recover_r2",     32'(r2_mod),  32'h16);
        chk("recover_mprime", 32'(m_prime), 32'h85);

        // Second start and modulus change mid-run are ignored
        @(posedge clk); #1;
        start   = 1'b1;
        modulus = 8'hB3;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt  = 0;
        repeat (4) @(posedge clk);
        #1;
        start   = 1'b1;
        modulus = 8'h03;
        chk("hold_r2_midrun", 32'(r2_mod), 32'h16);
        @(posedge clk); #1;
        start   = 1'b0;
        modulus = 8'h00;
        for (int i = 0; i < 25; i++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        chk("ign_dones",  32'(dcnt),    32'd1);
        chk("ign_r2",     32'(r2_mod),  32'h16);
        chk("ign_mprime", 32'(m_prime), 32'h85);

        // Reset in the middle of a run
        do_run(8'h03, lat, bcnt);
        @(posedge clk); #1;
        start   = 1'b1;
        modulus = 8'hB3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy",   32'(busy),    32'h0);
        chk("mrst_r2",     32'(r2_mod),  32'h0);
        chk("mrst_mprime", 32'(m_prime), 32'h0);
        chk("mrst_err",    32'(err),     32'h0);
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        chk("mrst_no_done", 32'(dcnt), 32'd0);
        do_run(8'hB3, lat, bcnt);
        chk("post_rst_lat",    32'(lat),     32'd17);
        chk("post_rst_r2",     32'(r2_mod),  32'h16);
        chk("post_rst_mprime", 32'(m_prime), 32'h85);

        // Sweep every odd modulus against the defining properties
        for (int m = 1; m < 256; m += 2) begin
            do_run(8'(m), lat, bcnt);
            prod = (32'(m) * 32'(m_prime) + 32'd1) & 32'hFF;
            chk($sformatf("sw_lat_%0d", m),    32'(lat),    32'd17);
            chk($sformatf("sw_inv_%0d", m),    prod,        32'h0);
            chk($sformatf("sw_r2_%0d", m),     32'(r2_mod), 32'(65536 % m));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
